// File: rtl/m6809_bus_fabric.sv
// 6809-style bus fabric: decodes core accesses into RAM, ROM and IO windows with per-region
// wait states, an IO ready handshake with timeout, and an error response for unmapped space.
module m6809_bus_fabric #(
    parameter logic [15:0] RAM_BASE   = 16'h0000,
    parameter int unsigned RAM_AW     = 12,
    parameter logic [15:0] IO_BASE    = 16'hE000,
    parameter int unsigned IO_AW      = 4,
    parameter logic [15:0] ROM_BASE   = 16'hFF00,
    parameter int unsigned ROM_AW     = 8,
    parameter int unsigned RAM_WAIT   = 0,
    parameter int unsigned IO_WAIT    = 2,
    parameter int unsigned ROM_WAIT   = 1,
    parameter int unsigned IO_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              cpu_vma,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_rw_n,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    output logic              cpu_ready,
    output logic              bus_err,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              rom_cs,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_rdata,
    output logic              io_cs,
    output logic              io_we,
    output logic [IO_AW-1:0]  io_addr,
    output logic [7:0]        io_wdata,
    input  logic [7:0]        io_rdata,
    input  logic              io_ready
);

    localparam logic [15:0] RAM_MASK = 16'hFFFF << RAM_AW;
    localparam logic [15:0] IO_MASK  = 16'hFFFF << IO_AW;
    localparam logic [15:0] ROM_MASK = 16'hFFFF << ROM_AW;
    localparam int unsigned MAX_AW0  = (RAM_AW > IO_AW) ? RAM_AW : IO_AW;
    localparam int unsigned MAX_AW   = (MAX_AW0 > ROM_AW) ? MAX_AW0 : ROM_AW;

    typedef enum logic [1:0] {StIdle, StAccess, StIoWait, StDone} state_t;
    typedef enum logic [1:0] {RgNone, RgRam, RgRom, RgIo} region_t;

    state_t              r_state;
    region_t             r_region;
    logic [MAX_AW-1:0]   r_addr;
    logic                r_rw_n;
    logic [7:0]          r_wdata;
    logic [3:0]          r_wcnt;
    logic [7:0]          r_tcnt;
    logic [7:0]          r_rdata;
    logic                r_ready;
    logic                r_err;
    logic                r_ram_cs;
    logic                r_rom_cs;
    logic                r_io_cs;

    logic                w_hit_ram;
    logic                w_hit_io;
    logic                w_hit_rom;
    region_t             w_region;
    logic [3:0]          w_wait;
    logic                w_last_access;

    assign w_hit_ram = ((cpu_addr ^ RAM_BASE) & RAM_MASK) == 16'h0000;
    assign w_hit_io  = ((cpu_addr ^ IO_BASE) & IO_MASK) == 16'h0000;
    assign w_hit_rom = ((cpu_addr ^ ROM_BASE) & ROM_MASK) == 16'h0000;

    // Overlapping windows resolve ROM first, then IO, then RAM.
    always_comb begin
        w_region = RgNone;
        w_wait   = 4'd0;
        if (w_hit_rom) begin
            w_region = RgRom;
            w_wait   = 4'(ROM_WAIT);
        end else if (w_hit_io) begin
            w_region = RgIo;
            w_wait   = 4'(IO_WAIT);
        end else if (w_hit_ram) begin
            w_region = RgRam;
            w_wait   = 4'(RAM_WAIT);
        end
    end

    assign w_last_access = (r_state == StAccess) && (r_wcnt == 4'd0);

    // Write strobes fire only on the cycle that completes the access.
    assign ram_we = w_last_access && (r_region == RgRam) && !r_rw_n;
    assign io_we  = !r_rw_n && (r_region == RgIo) && io_ready &&
                    (w_last_access || (r_state == StIoWait));

    assign ram_cs    = r_ram_cs;
    assign rom_cs    = r_rom_cs;
    assign io_cs     = r_io_cs;
    assign ram_addr  = r_addr[RAM_AW-1:0];
    assign rom_addr  = r_addr[ROM_AW-1:0];
    assign io_addr   = r_addr[IO_AW-1:0];
    assign ram_wdata = r_wdata;
    assign io_wdata  = r_wdata;
    assign cpu_din   = r_rdata;
    assign cpu_ready = r_ready;
    assign bus_err   = r_err;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state  <= StIdle;
            r_region <= RgNone;
            r_addr   <= '0;
            r_rw_n   <= 1'b0;
            r_wdata  <= 8'h00;
            r_wcnt   <= 4'd0;
            r_tcnt   <= 8'd0;
            r_rdata  <= 8'h00;
            r_ready  <= 1'b0;
            r_err    <= 1'b0;
            r_ram_cs <= 1'b0;
            r_rom_cs <= 1'b0;
            r_io_cs  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (cpu_vma) begin
                        r_addr   <= cpu_addr[MAX_AW-1:0];
                        r_rw_n   <= cpu_rw_n;
                        r_wdata  <= cpu_dout;
                        r_region <= w_region;
                        r_wcnt   <= w_wait;
                        r_ram_cs <= (w_region == RgRam);
                        r_rom_cs <= (w_region == RgRom);
                        r_io_cs  <= (w_region == RgIo);
                        r_state  <= StAccess;
                    end
                end
                StAccess: begin
                    if (r_wcnt != 4'd0) begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end else begin
                        case (r_region)
                            RgRam, RgRom: begin
                                if (r_rw_n) begin
                                    r_rdata <= (r_region == RgRam) ? ram_rdata : rom_rdata;
                                end
                                r_ram_cs <= 1'b0;
                                r_rom_cs <= 1'b0;
                                r_ready  <= 1'b1;
                                r_state  <= StDone;
                            end
                            RgIo: begin
                                if (io_ready) begin
                                    if (r_rw_n) begin
                                        r_rdata <= io_rdata;
                                    end
                                    r_io_cs <= 1'b0;
                                    r_ready <= 1'b1;
                                    r_state <= StDone;
                                end else begin
                                    r_tcnt  <= 8'(IO_TIMEOUT);
                                    r_state <= StIoWait;
                                end
                            end
                            default: begin
                                r_rdata <= 8'hFF;
                                r_err   <= 1'b1;
                                r_ready <= 1'b1;
                                r_state <= StDone;
                            end
                        endcase
                    end
                end
                StIoWait: begin
                    if (io_ready) begin
                        if (r_rw_n) begin
                            r_rdata <= io_rdata;
                        end
                        r_io_cs <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= StDone;
                    end else if (r_tcnt == 8'd0) begin
                        r_rdata <= 8'hFF;
                        r_err   <= 1'b1;
                        r_io_cs <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_tcnt <= r_tcnt - 8'd1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule
